// File: rtl/cpu_trace_pkg.sv
// Shared types and default widths for the CPU execution-trace capture block.
package cpu_trace_pkg;

   localparam int DEPTH_DEF   = 16;
   localparam int PC_W_DEF    = 32;
   localparam int INSTR_W_DEF = 32;
   localparam int SEQ_W_DEF   = 16;

   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic [SEQ_W_DEF-1:0]   seq;
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; the caller guarantees push/pop are legal.
module trace_fifo
   import cpu_trace_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = trace_entry_t,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  entry_t      wdata_i,
   output entry_t      rdata_o,
   output logic        valid_o,
   output logic [AW:0] count_o
);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr    <= '0;
         rptr    <= '0;
         count_o <= '0;
      end else begin
         if (push_i) wptr <= wptr + AW'(1);
         if (pop_i)  rptr <= rptr + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_o <= count_o + (AW+1)'(1);
            2'b01:   count_o <= count_o - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset; the head is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wptr] <= wdata_i;
   end

   assign valid_o = (count_o != '0);
   assign rdata_o = valid_o ? mem[rptr] : '0;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Per-cycle PC/instruction trace capture with sequence tagging and drop accounting.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter int  PC_W    = PC_W_DEF,
   parameter int  INSTR_W = INSTR_W_DEF,
   parameter int  SEQ_W   = SEQ_W_DEF,
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cap_en_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic               rd_valid_o,
   input  logic               rd_ready_i,
   output logic [SEQ_W-1:0]   rd_seq_o,
   output logic [PC_W-1:0]    rd_pc_o,
   output logic [INSTR_W-1:0] rd_instr_o,
   output logic [CW-1:0]      count_o,
   output logic               overflow_o,
   output logic [15:0]        drop_cnt_o
);

   typedef struct packed {
      logic [SEQ_W-1:0]   seq;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t           wdata;
   entry_t           head;
   logic [SEQ_W-1:0] seq;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign full  = (count_o == CW'(DEPTH));
   assign pop   = rd_valid_o & rd_ready_i;
   // A full FIFO still accepts a sample when the head leaves on the same edge.
   assign push  = cap_en_i & (~full | pop);
   assign drop  = cap_en_i & full & ~pop;
   assign wdata = '{seq: seq, pc: pc_i, instr: instr_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq        <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         if (cap_en_i) seq <= seq + SEQ_W'(1);
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != DROP_CNT_MAX) drop_cnt_o <= drop_cnt_o + 16'd1;
         end
      end
   end

   trace_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (head),
      .valid_o (rd_valid_o),
      .count_o (count_o)
   );

   assign rd_seq_o   = head.seq;
   assign rd_pc_o    = head.pc;
   assign rd_instr_o = head.instr;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: default instance plus a narrow-seq instance for wrap.
module tb_cpu_trace_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cap_en;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        ready;
   logic        valid;
   logic [15:0] rseq;
   logic [31:0] rpc;
   logic [31:0] rinstr;
   logic [4:0]  count;
   logic        ovf;
   logic [15:0] drops;

   logic        cap_b;
   logic [31:0] pc_b;
   logic        ready_b;
   logic        valid_b;
   logic [3:0]  rseq_b;
   logic [31:0] rpc_b;
   logic [31:0] rinstr_b;
   logic [2:0]  count_b;
   logic        ovf_b;
   logic [15:0] drops_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cpu_trace_buffer dut (
      .clk_i(clk), .rst_i(rst), .cap_en_i(cap_en), .pc_i(pc), .instr_i(instr),
      .rd_valid_o(valid), .rd_ready_i(ready), .rd_seq_o(rseq), .rd_pc_o(rpc),
      .rd_instr_o(rinstr), .count_o(count), .overflow_o(ovf), .drop_cnt_o(drops)
   );

   cpu_trace_buffer #(.DEPTH(4), .SEQ_W(4)) dut_w (
      .clk_i(clk), .rst_i(rst), .cap_en_i(cap_b), .pc_i(pc_b), .instr_i(32'h0),
      .rd_valid_o(valid_b), .rd_ready_i(ready_b), .rd_seq_o(rseq_b), .rd_pc_o(rpc_b),
      .rd_instr_o(rinstr_b), .count_o(count_b), .overflow_o(ovf_b), .drop_cnt_o(drops_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cap_en = 1'b0; ready = 1'b0; cap_b = 1'b0; ready_b = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic capture_n(input int n);
      for (int i = 0; i < n; i++) begin
         pc = 32'(i * 4); instr = 32'h1000_0000 + 32'(i); cap_en = 1'b1;
         tick();
      end
      cap_en = 1'b0;
   endtask

   task automatic test_reset();
      pc = '0; instr = '0; pc_b = '0;
      do_reset();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
      n_cmp++; if (drops !== 16'd0) begin n_err++; $display("FAIL reset_drops: got %0d want 0", drops); end
      n_cmp++; if ({rseq, rpc, rinstr} !== 80'd0) begin n_err++; $display("FAIL reset_head_zero: got %0h want 0", {rseq, rpc, rinstr}); end
   endtask

   task automatic test_single();
      cap_en = 1'b1; pc = 32'h0; instr = 32'h2001_0005;
      tick();
      cap_en = 1'b0;
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", valid); end
      n_cmp++; if (rseq !== 16'd0) begin n_err++; $display("FAIL single_seq: got %0d want 0", rseq); end
      n_cmp++; if (rpc !== 32'h0) begin n_err++; $display("FAIL single_pc: got %0h want 0", rpc); end
      n_cmp++; if (rinstr !== 32'h2001_0005) begin n_err++; $display("FAIL single_instr: got %0h want 20010005", rinstr); end
      n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_cmp++; if (valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL single_drain: got valid %0b count %0d want 0 0", valid, count); end
      // idle cycles with capture off must not consume sequence numbers
      tick(); tick(); tick();
      cap_en = 1'b1; pc = 32'h4; instr = 32'hABCD_0001;
      tick();
      cap_en = 1'b0;
      n_cmp++; if (rseq !== 16'd1) begin n_err++; $display("FAIL capoff_seq: got %0d want 1", rseq); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      capture_n(20);
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", count); end
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %0b want 1", ovf); end
      n_cmp++; if (drops !== 16'd4) begin n_err++; $display("FAIL fill_drops: got %0d want 4", drops); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (valid !== 1'b1 || rseq !== 16'(i) || rpc !== 32'(i * 4) || rinstr !== 32'h1000_0000 + 32'(i)) begin
            n_err++;
            $display("FAIL fill_drain[%0d]: got v%0b seq %0d pc %0h instr %0h want v1 seq %0d pc %0h instr %0h",
                     i, valid, rseq, rpc, rinstr, i, i * 4, 32'h1000_0000 + 32'(i));
         end
         ready = 1'b1;
         tick();
         ready = 1'b0;
      end
      n_cmp++; if (count !== 5'd0 || valid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got count %0d valid %0b want 0 0", count, valid); end
      n_cmp++; if (ovf !== 1'b1 || drops !== 16'd4) begin n_err++; $display("FAIL ovf_sticky: got ovf %0b drops %0d want 1 4", ovf, drops); end
   endtask

   task automatic test_full_pop_push();
      logic [31:0] exp_pc;
      do_reset();
      capture_n(16);
      for (int k = 0; k < 8; k++) begin
         pc = 32'h100 + 32'(k * 4); cap_en = 1'b1; ready = 1'b1;
         n_cmp++; if (rseq !== 16'(k)) begin n_err++; $display("FAIL fullpop_head[%0d]: got %0d want %0d", k, rseq, k); end
         tick();
         n_cmp++;
         if (count !== 5'd16 || drops !== 16'd0) begin
            n_err++;
            $display("FAIL fullpop_state[%0d]: got count %0d drops %0d want 16 0", k, count, drops);
         end
      end
      cap_en = 1'b0;
      for (int j = 0; j < 16; j++) begin
         exp_pc = (j < 8) ? 32'((8 + j) * 4) : 32'h100 + 32'((j - 8) * 4);
         n_cmp++;
         if (rseq !== 16'(8 + j) || rpc !== exp_pc) begin
            n_err++;
            $display("FAIL fullpop_drain[%0d]: got seq %0d pc %0h want seq %0d pc %0h", j, rseq, rpc, 8 + j, exp_pc);
         end
         tick();
      end
      ready = 1'b0;
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL fullpop_empty: got %0d want 0", count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      cap_en = 1'b1;
      pc = 32'h40; instr = 32'hAAAA_0000; tick();
      pc = 32'h44; instr = 32'hBBBB_0001; tick();
      pc = 32'h48; instr = 32'hCCCC_0002; tick();
      cap_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (valid !== 1'b1 || rseq !== 16'd0 || rpc !== 32'h40 || rinstr !== 32'hAAAA_0000) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got v%0b seq %0d pc %0h instr %0h want v1 seq 0 pc 40 instr aaaa0000",
                     i, valid, rseq, rpc, rinstr);
         end
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_cmp++;
      if (rseq !== 16'd1 || rpc !== 32'h44 || rinstr !== 32'hBBBB_0001 || count !== 5'd2) begin
         n_err++;
         $display("FAIL bp_advance: got seq %0d pc %0h instr %0h count %0d want 1 44 bbbb0001 2", rseq, rpc, rinstr, count);
      end
   endtask

   task automatic test_seq_wrap();
      do_reset();
      cap_b = 1'b1; ready_b = 1'b1;
      for (int i = 0; i < 18; i++) begin
         pc_b = 32'(i);
         tick();
         n_cmp++;
         if (valid_b !== 1'b1 || rseq_b !== 4'(i % 16) || rpc_b !== 32'(i)) begin
            n_err++;
            $display("FAIL wrap[%0d]: got v%0b seq %0d pc %0h want v1 seq %0d pc %0h", i, valid_b, rseq_b, rpc_b, i % 16, i);
         end
      end
      cap_b = 1'b0;
      tick();
      ready_b = 1'b0;
      n_cmp++; if (count_b !== 3'd0 || ovf_b !== 1'b0) begin n_err++; $display("FAIL wrap_end: got count %0d ovf %0b want 0 0", count_b, ovf_b); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      capture_n(19);
      for (int i = 0; i < 9; i++) begin
         ready = 1'b1;
         tick();
      end
      ready = 1'b0;
      n_cmp++; if (count !== 5'd7 || ovf !== 1'b1) begin n_err++; $display("FAIL mid_pre: got count %0d ovf %0b want 7 1", count, ovf); end
      rst = 1'b1; cap_en = 1'b1; ready = 1'b1; pc = 32'h999;
      tick();
      rst = 1'b0; cap_en = 1'b0; ready = 1'b0;
      n_cmp++;
      if (count !== 5'd0 || valid !== 1'b0 || ovf !== 1'b0 || drops !== 16'd0) begin
         n_err++;
         $display("FAIL mid_reset: got count %0d valid %0b ovf %0b drops %0d want 0 0 0 0", count, valid, ovf, drops);
      end
      cap_en = 1'b1; pc = 32'h0000_0ABC; instr = 32'h1234_5678;
      tick();
      cap_en = 1'b0;
      n_cmp++;
      if (rseq !== 16'd0 || rpc !== 32'h0000_0ABC || count !== 5'd1) begin
         n_err++;
         $display("FAIL mid_first: got seq %0d pc %0h count %0d want 0 abc 1", rseq, rpc, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_pop_push();
      test_backpressure();
      test_seq_wrap();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
